// File: rtl/riscv_muldiv_if.sv
// Issue/result bundle between the execute stage and the RV32M multiply/divide unit.
// The master side issues operations; the slave side is the unit itself.
interface riscv_muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, srcA, srcB, flush,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, funct3, srcA, srcB, flush,
    output busy, stall, done, result
  );
endinterface

// File: rtl/riscv_muldiv_unit.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiply and restoring divide.
// Operands are normalised to magnitudes at issue; the sign is applied when the result is latched.
module riscv_muldiv_unit #(
  parameter int unsigned XLEN      = 32,
  parameter bit          FAST_ZERO = 1'b1
) (
  input logic           clk,
  input logic           reset,
  riscv_muldiv_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(XLEN + 1);
  localparam int unsigned PW    = 2 * XLEN;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [PW-1:0]    acc_q;
  logic [XLEN-1:0]  opb_q;
  logic [2:0]       op_q;
  logic             neg_q;
  logic [XLEN-1:0]  result_q;

  logic load, fast, step, finish;

  // Issue-time decode: signedness, magnitudes, result sign and the short-cut cases
  logic            a_sgn, b_sgn, a_neg, b_neg, is_div_in, b_zero, ovf, fast_hit, neg_in;
  logic [XLEN-1:0] abs_a, abs_b, fast_res;

  always_comb begin
    is_div_in = bus.funct3[2];
    a_sgn     = (bus.funct3 != 3'b011) && !(bus.funct3[2] && bus.funct3[0]);
    b_sgn     = a_sgn && (bus.funct3 != 3'b010);
    a_neg     = a_sgn && bus.srcA[XLEN-1];
    b_neg     = b_sgn && bus.srcB[XLEN-1];
    abs_a     = a_neg ? -bus.srcA : bus.srcA;
    abs_b     = b_neg ? -bus.srcB : bus.srcB;
    b_zero    = (bus.srcB == '0);
    ovf       = is_div_in && b_sgn && (bus.srcA == MOST_NEG) && (bus.srcB == '1);
    fast_hit  = FAST_ZERO && is_div_in && (b_zero || ovf);
    // A zero divisor keeps the quotient at all-ones regardless of the dividend sign
    if (is_div_in) neg_in = bus.funct3[1] ? a_neg : ((a_neg ^ b_neg) && !b_zero);
    else           neg_in = a_neg ^ b_neg;
    if (bus.funct3[1]) fast_res = b_zero ? bus.srcA : '0;
    else               fast_res = b_zero ? '1 : bus.srcA;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    fast    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          load = 1'b1;
          if (fast_hit) begin
            fast    = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(XLEN)) begin
          finish  = 1'b1;
          state_d = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One iteration of each algorithm; acc holds {high product, multiplier} or {remainder, quotient}
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic            borrow;
  logic [PW-1:0]   mul_next, div_next, mul_full;
  logic [XLEN-1:0] div_raw, div_res, calc_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[PW-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    borrow    = div_diff[XLEN];
    div_next  = {(borrow ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0]), acc_q[XLEN-2:0], !borrow};
    mul_full  = neg_q ? -acc_q : acc_q;
    div_raw   = op_q[1] ? acc_q[PW-1:XLEN] : acc_q[XLEN-1:0];
    div_res   = neg_q ? -div_raw : div_raw;
    if (op_q[2])             calc_res = div_res;
    else if (op_q[1:0] == 2'b00) calc_res = mul_full[XLEN-1:0];
    else                     calc_res = mul_full[PW-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      if (load) begin
        op_q  <= bus.funct3;
        neg_q <= neg_in;
        opb_q <= abs_b;
        acc_q <= {{XLEN{1'b0}}, abs_a};
        cnt_q <= '0;
      end else if (step) begin
        acc_q <= op_q[2] ? div_next : mul_next;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (finish)    result_q <= calc_res;
      else if (fast) result_q <= fast_res;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  // Holds the issuing instruction in execute until the result is ready
  assign bus.stall  = !reset && ((state_q == CALC) ||
                                 ((state_q == IDLE) && bus.start && !bus.flush));
endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Self-checking bench for riscv_muldiv_unit (XLEN=32, FAST_ZERO=1): directed vectors,
// randomized operations against an arithmetic reference, and flush/reset/ignored-start sequences.
module tb_riscv_muldiv_unit;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  riscv_muldiv_if #(.XLEN(32)) bus();

  riscv_muldiv_unit #(.XLEN(32), .FAST_ZERO(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic plus the M-extension special cases
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    r  = '0;
    case (f)
      3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: begin if (b == 0) r = '1; else begin p = 64'(sa / sb); r = p[31:0]; end end
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin if (b == 0) r = a; else begin p = 64'(sa % sb); r = p[31:0]; end end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Divide by zero and signed overflow finish in one cycle; everything else takes 34
  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
    if (f[2] && ((b == 0) || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Caller is just after a negedge; start is held across exactly one rising edge (edge N)
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic st);
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.srcA   = a;
    bus.srcB   = b;
    #1;
    st = bus.stall;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int stalls, output logic st_done,
                           output logic [31:0] res);
    lat     = 0;
    stalls  = 0;
    st_done = 1'b0;
    res     = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat     = k;
        res     = bus.result;
        st_done = bus.stall;
        break;
      end
      if (bus.stall) stalls++;
    end
  endtask

  task automatic run_op(input string name, input bit sync, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    logic        st, st_done;
    int          lat, stalls;
    logic [31:0] res;
    if (sync) @(negedge clk);
    issue(f, a, b, st);
    wait_done(lat, stalls, st_done, res);
    check({name, " stall at issue"}, 32'(st), 32'd1);
    check({name, " result"}, res, exp);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " stall cycles"}, 32'(stalls), 32'(exp_lat - 1));
    check({name, " stall in done"}, 32'(st_done), 32'd0);
    @(negedge clk);
    check({name, " done/busy after"}, {30'd0, bus.done, bus.busy}, 32'd0);
  endtask

  initial begin
    logic        st;
    int          lat, cnt;
    logic [31:0] res;
    logic [2:0]  f;
    logic [31:0] a, b;

    checks = 0;
    errors = 0;

    vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
    vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    vecs[2]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34};
    vecs[3]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[4]  = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[5]  = '{3'd5, 32'd100,      32'd0,        32'hFFFFFFFF, 1};
    vecs[6]  = '{3'd7, 32'd100,      32'd0,        32'd100,      1};
    vecs[7]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
    vecs[8]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
    vecs[9]  = '{3'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1};
    vecs[10] = '{3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1};
    vecs[11] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34};
    vecs[12] = '{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34};
    vecs[13] = '{3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34};

    // Reset with start asserted: start must be ignored and stall held low
    reset      = 1'b1;
    bus.start  = 1'b1;
    bus.flush  = 1'b0;
    bus.funct3 = 3'd0;
    bus.srcA   = 32'd3;
    bus.srcB   = 32'd4;
    repeat (3) @(negedge clk);
    check("reset stall", 32'(bus.stall), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", bus.result, 32'd0);
    reset     = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("post-reset busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 14; i++)
      run_op($sformatf("vec%0d", i), 1'b1, vecs[i].f, vecs[i].a, vecs[i].b,
             vecs[i].exp, vecs[i].lat);

    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run_op($sformatf("rand%0d f%0d", i, f), 1'b1, f, a, b, model(f, a, b), model_lat(f, a, b));
    end

    // flush together with start in IDLE: nothing accepted
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.srcB  = 32'd0;
    bus.funct3 = 3'd4;
    #1;
    check("flush+start stall", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush+start busy", {30'd0, bus.busy, bus.done}, 32'd0);

    // flush at CALC cycle 10, then a fresh start in the very next cycle
    run_op("pre-flush", 1'b1, 3'd0, 32'd3, 32'd5, 32'd15, 34);
    @(negedge clk);
    issue(3'd5, 32'd1000, 32'd7, st);
    cnt = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush no done", 32'(cnt) + 32'(bus.done), 32'd0);
    check("flush busy", 32'(bus.busy), 32'd0);
    check("flush result held", bus.result, 32'd15);
    run_op("after-flush", 1'b0, 3'd5, 32'd1000, 32'd7, 32'd142, 34);

    // start while busy (CALC and DONE) is ignored and not queued
    @(negedge clk);
    issue(3'd0, 32'd9, 32'd11, st);
    lat = 0;
    res = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 5) begin
        bus.start  = 1'b1;
        bus.funct3 = 3'd4;
        bus.srcA   = 32'd77;
        bus.srcB   = 32'd0;
      end else begin
        bus.start = 1'b0;
      end
      #1;
      if (bus.done) begin
        lat = k;
        res = bus.result;
        break;
      end
    end
    check("busy-start latency", 32'(lat), 32'd34);
    check("busy-start result", res, 32'd99);
    bus.start  = 1'b1;
    bus.funct3 = 3'd5;
    bus.srcA   = 32'd5;
    bus.srcB   = 32'd0;
    #1;
    check("done-start stall", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.busy || bus.done) cnt++;
    end
    check("done-start not queued", 32'(cnt), 32'd0);
    check("done-start result", bus.result, 32'd99);

    // reset at CALC cycle 20 aborts without a done pulse and clears result
    @(negedge clk);
    issue(3'd3, 32'h12345678, 32'h9ABCDEF0, st);
    cnt = 0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid-reset stall", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid-reset busy", 32'(bus.busy), 32'd0);
    check("mid-reset result", bus.result, 32'd0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    check("mid-reset no done", 32'(cnt), 32'd0);
    run_op("after-reset", 1'b1, 3'd6, 32'd100, 32'hFFFFFFF9,
           model(3'd6, 32'd100, 32'hFFFFFFF9), 34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_muldiv_unit.md
RISCV_MULDIV_UNIT -- requirements
Module: riscv_muldiv_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width.
REQ-002 The block SHALL have parameter FAST_ZERO, default 1; when 1, divide-by-zero and signed overflow complete without iteration.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start, input, 1 bit: request to begin an operation.
REQ-006 Port funct3, input, 3 bits: operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 Port srcA / srcB, inputs, XLEN bits each: rs1 and rs2 operands.
REQ-008 Port flush, input, 1 bit: kill of the in-flight operation, driven by the pipeline flush of the execute stage.
REQ-009 Port busy, output, 1 bit: an operation is in progress.
REQ-010 Port stall, output, 1 bit: pipeline stall request to the hazard unit.
REQ-011 Port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-012 Port result, output, XLEN bits: the operation result.

Function
REQ-013 The FSM SHALL have the states IDLE, CALC and DONE.
REQ-014 In IDLE, start=1 with flush=0 SHALL latch funct3, srcA and srcB at that edge, called edge N.
REQ-015 Operand normalisation SHALL follow the op:
- signed ops take the absolute value of the operands and record the result sign;
- MULHSU treats srcA as signed and srcB as unsigned.
REQ-016 Multiply SHALL use radix-2 shift-add over a 2*XLEN product, one bit per cycle, XLEN CALC cycles.
REQ-017 Divide SHALL use restoring shift-subtract, one quotient bit per cycle, XLEN CALC cycles.
REQ-018 After CALC the FSM SHALL enter DONE, so done=1 in the cycle following edge N+XLEN+1; DONE SHALL then return to IDLE.
REQ-019 Result selection SHALL be:
- MUL: low XLEN bits of the product;
- MULH, MULHSU, MULHU: high XLEN bits of the signed/mixed/unsigned product;
- DIV, DIVU: quotient; REM, REMU: remainder;
- all results sign-corrected per the RISC-V M extension.
REQ-020 Divide by zero SHALL return quotient all-ones and remainder = srcA, for both signed and unsigned ops.
REQ-021 Signed overflow (srcA = most-negative, srcB = -1) SHALL return DIV = srcA and REM = 0.
REQ-022 With FAST_ZERO=1, the cases in REQ-020 and REQ-021 SHALL go IDLE -> DONE directly, with done in the cycle after edge N.
REQ-023 result SHALL be registered and held unchanged from DONE until the next DONE.
REQ-024 busy SHALL be 1 in CALC and DONE, and 0 in IDLE.
REQ-025 stall SHALL equal (state==CALC) OR (state==IDLE AND start AND NOT flush), combinationally, so the issuing instruction holds in execute.
REQ-026 stall SHALL be 0 in DONE, so the pipeline advances in the same cycle the result is valid.
REQ-027 start asserted in CALC or DONE SHALL be ignored; no queuing.
REQ-028 flush=1 in any state SHALL force IDLE at the next edge, with no done pulse and result unchanged.
REQ-029 If flush and start are both high in IDLE, flush SHALL win and nothing is accepted.
REQ-030 The counter SHALL be ceil(log2(XLEN+1)) bits wide and SHALL terminate on reaching XLEN with no wrap.

Reset
REQ-031 With reset=1 at an edge, the block SHALL enter IDLE with busy=0, done=0, result=0, counter=0 and internal operands cleared.
REQ-032 Reset SHALL take priority over start and flush, and SHALL abort any in-progress operation without a done pulse.
REQ-033 stall SHALL be 0 while reset is asserted.

Verification (XLEN=32, FAST_ZERO=1)
REQ-034 MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB with done in the cycle after edge N+33; stall high through edge N+32.
REQ-035 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE, and MULH of the same operands -> 0x00000000.
REQ-036 Division boundary cases:
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, and REM of the same -> 0, done in the cycle after edge N;
- DIVU 100 / 0 -> 0xFFFFFFFF, and REMU 100 / 0 -> 100.
REQ-037 Signed divide: DIV -7 / 2 -> 0xFFFFFFFD and REM -7 / 2 -> 0xFFFFFFFF, after 33 cycles.
REQ-038 flush at CALC cycle 10 -> IDLE next edge, no done, result holds the prior value, and a new start the following cycle completes correctly.
REQ-039 reset at CALC cycle 20 -> busy=0, result=0, no done; start while busy is ignored and the original result is unaffected.
